pc_update_ctrl: RTL and testbench
=================================

# pc_update_ctrl

Sequencer that drives the 3-bit PC-source select and the PC/EPC write strobes of the multicycle datapath. The main control unit hands it the PC-update decision for the current instruction: branch/jump class plus ALU flags and exception flags. It resolves branch conditions, prioritises exceptions, runs the multi-cycle exception-vector fetch, and then pulses the selected PC write. It sits between the main control FSM and the PC-source mux / PC / EPC registers.

## Interface
- MEM_LAT, 2: cycles from mem_read_exc assertion to valid MemDataReg byte (1..7)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request from main control; sampled only in IDLE
- op_class  in  4  0 SEQ, 1 BEQ, 2 BNE, 3 BLE, 4 BGT, 5 JUMP, 6 JR, 7 RTE, 8 MEMPC; others = SEQ
- zero  in  1  ALU zero flag, valid with start
- gt  in  1  ALU greater-than flag, valid with start
- exc_opcode  in  1  invalid opcode
- exc_overflow  in  1  arithmetic overflow
- exc_div0  in  1  divide by zero
- pc_source  out  3  mux select: 000 PC, 001 ALU, 010 EPC, 011 MemDataReg, 100 ALUOut, 101 ExceptionByteExtendido, 110 JumpAddress, 111 RegA
- pc_write  out  1  PC load strobe
- epc_write  out  1  EPC load strobe
- mem_read_exc  out  1  request memory byte read at exc_addr
- exc_addr  out  32  exception vector address: 253 opcode, 254 overflow, 255 div0
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, UPDATE, EXC_SAVE, EXC_READ, EXC_WAIT, EXC_LOAD, DONE.
- IDLE + start, no exception flag → UPDATE. Any exception flag → EXC_SAVE; the exception is latched.
- Exception priority: opcode > overflow > div0. Only the winner's address is latched.
- UPDATE (1 cycle):
  - pc_source comes from op_class: SEQ 001; BEQ/BNE/BLE/BGT 100; JUMP 110; JR 111; RTE 010; MEMPC 011.
  - pc_write = 1 for non-branch classes.
  - Branch pc_write: BEQ zero; BNE !zero; BLE !gt; BGT gt. zero and gt are latched at start.
  - Not-taken branch: pc_source still 100, pc_write 0.
  - Next state: DONE.
- EXC_SAVE: epc_write = 1 for 1 cycle; the datapath supplies PC. → EXC_READ.
- EXC_READ: mem_read_exc = 1 and exc_addr = latched vector for 1 cycle. → EXC_WAIT.
- EXC_WAIT: hold exc_addr for MEM_LAT−1 cycles using a 3-bit down-counter. → EXC_LOAD.
- EXC_LOAD: pc_source 101, pc_write 1 for 1 cycle. → DONE.
- DONE: done = 1. → IDLE.
- start outside IDLE is ignored, with no queueing.
- Flags change after start: no effect; all inputs are latched.

## Timing
- All outputs are registered and decoded from state plus latched fields.
- Reset values: pc_source 000, pc_write 0, epc_write 0, mem_read_exc 0, exc_addr 0, busy 0, done 0. State = IDLE, counter 0.
- Normal path: start at cycle N, pc_write (if taken) at N+1, done at N+2. Next start accepted at N+3.
- Exception path: start at N, epc_write at N+1, mem_read_exc at N+2, pc_write with 101 at N+2+MEM_LAT, done at N+3+MEM_LAT.
- Outside strobe cycles pc_source holds 000 and no write strobe is ever active.
- Reset asserted mid-sequence: abort on that edge, all outputs return to reset values next cycle, and no pending strobe fires.
- epc_write and pc_write are never high in the same cycle.

## Structure
- Shared package pc_ctrl_pkg holds:
  - PCSource encoding localparams (PCS_PC … PCS_REGA)
  - op_class codes
  - vector addresses VEC_OPCODE = 32'd253, VEC_OVF = 32'd254, VEC_DIV0 = 32'd255
  - state encoding
- One natural sub-module: exc_priority, a combinational 3-flag priority encoder returning valid + vector address.

## Test plan
- SEQ start → cycle+1: pc_source 001, pc_write 1; cycle+2: done 1. busy is high over exactly 2 cycles.
- BEQ with zero=1 → pc_source 100, pc_write 1. BNE with zero=1 → pc_source 100, pc_write 0, done still pulses.
- BGT gt=1 → taken; BLE gt=1 → not taken. Flags toggled after start have no effect.
- exc_overflow=1 and exc_div0=1 together, MEM_LAT=2:
  - epc_write at +1
  - mem_read_exc with exc_addr 254 at +2
  - pc_source 101 and pc_write at +4
  - done at +5
- exc_opcode during JR → vector 253; the JR path is never taken and no 111 select appears.
- reset during EXC_WAIT → all outputs 0 next cycle. A subsequent SEQ start completes normally. start pulsed while busy is ignored.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-update sequencer: PC-source selects, op classes,
// exception vectors and FSM states.
package pc_ctrl_pkg;

    localparam logic [2:0] PCS_PC      = 3'b000;
    localparam logic [2:0] PCS_ALU     = 3'b001;
    localparam logic [2:0] PCS_EPC     = 3'b010;
    localparam logic [2:0] PCS_MDR     = 3'b011;
    localparam logic [2:0] PCS_ALUOUT  = 3'b100;
    localparam logic [2:0] PCS_EXCBYTE = 3'b101;
    localparam logic [2:0] PCS_JUMP    = 3'b110;
    localparam logic [2:0] PCS_REGA    = 3'b111;

    localparam logic [31:0] VEC_OPCODE = 32'd253;
    localparam logic [31:0] VEC_OVF    = 32'd254;
    localparam logic [31:0] VEC_DIV0   = 32'd255;

    typedef enum logic [3:0] {
        OP_SEQ   = 4'd0,
        OP_BEQ   = 4'd1,
        OP_BNE   = 4'd2,
        OP_BLE   = 4'd3,
        OP_BGT   = 4'd4,
        OP_JUMP  = 4'd5,
        OP_JR    = 4'd6,
        OP_RTE   = 4'd7,
        OP_MEMPC = 4'd8
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UPDATE   = 3'd1,
        ST_EXC_SAVE = 3'd2,
        ST_EXC_READ = 3'd3,
        ST_EXC_WAIT = 3'd4,
        ST_EXC_LOAD = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Unused op_class encodings behave as sequential fetch.
    function automatic op_class_e op_sanitize(input logic [3:0] raw);
        if (raw <= 4'd8) begin
            return op_class_e'(raw);
        end else begin
            return OP_SEQ;
        end
    endfunction

    function automatic logic [2:0] op_pc_source(input op_class_e op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLE, OP_BGT: return PCS_ALUOUT;
            OP_JUMP:                        return PCS_JUMP;
            OP_JR:                          return PCS_REGA;
            OP_RTE:                         return PCS_EPC;
            OP_MEMPC:                       return PCS_MDR;
            default:                        return PCS_ALU;
        endcase
    endfunction

    function automatic logic op_pc_write(input op_class_e op, input logic zero,
                                         input logic gt);
        case (op)
            OP_BEQ:  return zero;
            OP_BNE:  return !zero;
            OP_BLE:  return !gt;
            OP_BGT:  return gt;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/pc_update_ctrl_exc_priority.sv
// Fixed-priority exception encoder: opcode beats overflow beats divide-by-zero.
module pc_update_ctrl_exc_priority
    import pc_ctrl_pkg::*;
(
    input  logic        exc_opcode_i,
    input  logic        exc_overflow_i,
    input  logic        exc_div0_i,
    output logic        valid_o,
    output logic [31:0] vec_o
);

    // Select the winning exception vector.
    always_comb begin
        valid_o = exc_opcode_i | exc_overflow_i | exc_div0_i;
        if (exc_opcode_i) begin
            vec_o = VEC_OPCODE;
        end else if (exc_overflow_i) begin
            vec_o = VEC_OVF;
        end else if (exc_div0_i) begin
            vec_o = VEC_DIV0;
        end else begin
            vec_o = 32'd0;
        end
    end

endmodule

// File: rtl/pc_update_ctrl.sv
// PC-update sequencer: resolves branches, runs the exception-vector fetch and
// pulses PC/EPC writes. Outputs are registered from the next state.
module pc_update_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_class,
    input  logic        zero,
    input  logic        gt,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_read_exc,
    output logic [31:0] exc_addr,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] WAIT_LOAD = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    state_e      state_q, state_d;
    op_class_e   op_q, op_d;
    logic        zero_q, zero_d;
    logic        gt_q, gt_d;
    logic [31:0] vec_q, vec_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        exc_valid_s;
    logic [31:0] exc_vec_s;

    logic [2:0]  pc_source_q, pc_source_d;
    logic        pc_write_q, pc_write_d;
    logic        epc_write_q, epc_write_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    pc_update_ctrl_exc_priority u_exc_priority (
        .exc_opcode_i   (exc_opcode),
        .exc_overflow_i (exc_overflow),
        .exc_div0_i     (exc_div0),
        .valid_o        (exc_valid_s),
        .vec_o          (exc_vec_s)
    );

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SEQ;
            zero_q      <= 1'b0;
            gt_q        <= 1'b0;
            vec_q       <= 32'd0;
            cnt_q       <= 3'd0;
            pc_source_q <= PCS_PC;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            exc_addr_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            zero_q      <= zero_d;
            gt_q        <= gt_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            pc_source_q <= pc_source_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            mem_read_q  <= mem_read_d;
            exc_addr_q  <= exc_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; request fields are captured only on an accepted start.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        zero_d  = zero_q;
        gt_d    = gt_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_sanitize(op_class);
                    zero_d  = zero;
                    gt_d    = gt;
                    vec_d   = exc_vec_s;
                    state_d = exc_valid_s ? ST_EXC_SAVE : ST_UPDATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE:   state_d = ST_DONE;
            ST_EXC_SAVE: state_d = ST_EXC_READ;
            ST_EXC_READ: begin
                if (MEM_LAT > 1) begin
                    state_d = ST_EXC_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_EXC_LOAD;
                end
            end
            ST_EXC_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_EXC_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_EXC_LOAD: state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered strobes line up with it.
    always_comb begin
        pc_source_d = PCS_PC;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        mem_read_d  = 1'b0;
        exc_addr_d  = 32'd0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = 1'b0;
        case (state_d)
            ST_UPDATE: begin
                pc_source_d = op_pc_source(op_d);
                pc_write_d  = op_pc_write(op_d, zero_d, gt_d);
            end
            ST_EXC_SAVE: epc_write_d = 1'b1;
            ST_EXC_READ: begin
                mem_read_d = 1'b1;
                exc_addr_d = vec_d;
            end
            ST_EXC_WAIT: exc_addr_d = vec_d;
            ST_EXC_LOAD: begin
                pc_source_d = PCS_EXCBYTE;
                pc_write_d  = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: pc_source_d = PCS_PC;
        endcase
    end

    assign pc_source    = pc_source_q;
    assign pc_write     = pc_write_q;
    assign epc_write    = epc_write_q;
    assign mem_read_exc = mem_read_q;
    assign exc_addr     = exc_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed bench for pc_update_ctrl with MEM_LAT = 2.
module tb_pc_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op_class;
    logic        zero, gt;
    logic        exc_opcode, exc_overflow, exc_div0;
    logic [2:0]  pc_source;
    logic        pc_write, epc_write, mem_read_exc, busy, done;
    logic [31:0] exc_addr;

    int n_pass  = 0;
    int n_total = 0;

    pc_update_ctrl #(.MEM_LAT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_class     (op_class),
        .zero         (zero),
        .gt           (gt),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_source    (pc_source),
        .pc_write     (pc_write),
        .epc_write    (epc_write),
        .mem_read_exc (mem_read_exc),
        .exc_addr     (exc_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // {pc_source, pc_write, epc_write, mem_read_exc, busy, done}
    function automatic logic [7:0] outv();
        return {pc_source, pc_write, epc_write, mem_read_exc, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; op_class = 4'd0; zero = 1'b0; gt = 1'b0;
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_0_0 || exc_addr !== 32'd0)
            $display("FAIL reset_state got %b addr %0d exp 00000000 addr 0", outv(), exc_addr);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_seq();
        op_class = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (outv() !== 8'b001_1_0_0_1_0)
            $display("FAIL seq_update got %b exp 00110010", outv());
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_1_1)
            $display("FAIL seq_done got %b exp 00000011", outv());
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_0_0)
            $display("FAIL seq_idle got %b exp 00000000", outv());
        else n_pass++;
    endtask

    // Branch vectors: {op, zero, gt, expected pc_write}
    task automatic test_branch();
        logic [6:0] tbl [6] = '{
            {4'd1, 1'b1, 1'b0, 1'b1},   // BEQ taken
            {4'd2, 1'b1, 1'b0, 1'b0},   // BNE not taken
            {4'd4, 1'b0, 1'b1, 1'b1},   // BGT taken
            {4'd3, 1'b0, 1'b1, 1'b0},   // BLE not taken
            {4'd1, 1'b0, 1'b1, 1'b0},   // BEQ not taken
            {4'd3, 1'b1, 1'b0, 1'b1}    // BLE taken
        };
        for (int i = 0; i < 6; i++) begin
            op_class = tbl[i][6:3]; zero = tbl[i][2]; gt = tbl[i][1];
            start = 1'b1;
            tick();
            start = 1'b0; zero = ~zero; gt = ~gt;
            n_total++;
            if (outv() !== {3'b100, tbl[i][0], 4'b0010})
                $display("FAIL branch_%0d got %b exp %b", i, outv(), {3'b100, tbl[i][0], 4'b0010});
            else n_pass++;
            tick();
            n_total++;
            if (outv() !== 8'b000_0_0_0_1_1)
                $display("FAIL branch_done_%0d got %b exp 00000011", i, outv());
            else n_pass++;
            tick();
        end
    endtask

    // Unconditional classes: {op, expected pc_source}
    task automatic test_jumps();
        logic [6:0] tbl [5] = '{
            {4'd5, 3'b110}, {4'd6, 3'b111}, {4'd7, 3'b010},
            {4'd8, 3'b011}, {4'd12, 3'b001}
        };
        for (int i = 0; i < 5; i++) begin
            op_class = tbl[i][6:3];
            start = 1'b1;
            tick();
            start = 1'b0;
            n_total++;
            if (outv() !== {tbl[i][2:0], 5'b10010})
                $display("FAIL jump_%0d got %b exp %b", i, outv(), {tbl[i][2:0], 5'b10010});
            else n_pass++;
            tick(); tick();
        end
    endtask

    task automatic test_exc_ovf_div0();
        op_class = 4'd0; exc_overflow = 1'b1; exc_div0 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
        n_total++;
        if (outv() !== 8'b000_0_1_0_1_0 || exc_addr !== 32'd0)
            $display("FAIL exc_save got %b addr %0d exp 00001010 addr 0", outv(), exc_addr);
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_1_1_0 || exc_addr !== 32'd254)
            $display("FAIL exc_read got %b addr %0d exp 00000110 addr 254", outv(), exc_addr);
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_1_0 || exc_addr !== 32'd254)
            $display("FAIL exc_wait got %b addr %0d exp 00000010 addr 254", outv(), exc_addr);
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b101_1_0_0_1_0)
            $display("FAIL exc_load got %b exp 10110010", outv());
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_1_1)
            $display("FAIL exc_done got %b exp 00000011", outv());
        else n_pass++;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_0_0)
            $display("FAIL exc_idle got %b exp 00000000", outv());
        else n_pass++;
    endtask

    task automatic test_exc_jr();
        logic saw_rega = 1'b0;
        logic [31:0] addr_at2 = 32'd0;
        logic [7:0]  out_at4 = 8'd0;
        op_class = 4'd6; exc_opcode = 1'b1; exc_overflow = 1'b1; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0; exc_opcode = 1'b0; exc_overflow = 1'b0;
            if (pc_source === 3'b111) saw_rega = 1'b1;
            if (c == 2) addr_at2 = mem_read_exc ? exc_addr : 32'hFFFF_FFFF;
            if (c == 4) out_at4 = outv();
        end
        n_total++;
        if (addr_at2 !== 32'd253)
            $display("FAIL jr_exc_vector got %0d exp 253", addr_at2);
        else n_pass++;
        n_total++;
        if (saw_rega !== 1'b0)
            $display("FAIL jr_no_rega got %b exp 0", saw_rega);
        else n_pass++;
        n_total++;
        if (out_at4 !== 8'b101_1_0_0_1_0)
            $display("FAIL jr_exc_load got %b exp 10110010", out_at4);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] strobes = 8'd0;
        exc_div0 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; exc_div0 = 1'b0;
        tick(); tick();
        n_total++;
        if (exc_addr !== 32'd255 || busy !== 1'b1)
            $display("FAIL div0_wait got addr %0d busy %b exp addr 255 busy 1", exc_addr, busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (outv() !== 8'b000_0_0_0_0_0 || exc_addr !== 32'd0)
            $display("FAIL reset_mid got %b addr %0d exp 00000000 addr 0", outv(), exc_addr);
        else n_pass++;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            strobes = strobes | outv();
        end
        n_total++;
        if (strobes !== 8'd0)
            $display("FAIL reset_no_pending got %b exp 00000000", strobes);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [7:0] after = 8'd0;
        op_class = 4'd0; start = 1'b1;
        tick();
        op_class = 4'd5;   // start stays high: must be ignored while busy
        n_total++;
        if (outv() !== 8'b001_1_0_0_1_0)
            $display("FAIL busy_update got %b exp 00110010", outv());
        else n_pass++;
        tick();
        start = 1'b0;
        n_total++;
        if (outv() !== 8'b000_0_0_0_1_1)
            $display("FAIL busy_done got %b exp 00000011", outv());
        else n_pass++;
        tick();
        after = outv();
        tick();
        after = after | outv();
        n_total++;
        if (after !== 8'd0)
            $display("FAIL busy_no_queue got %b exp 00000000", after);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        op_class = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();            // cycle N+3: idle, next start accepted here
        op_class = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (outv() !== 8'b110_1_0_0_1_0)
            $display("FAIL b2b_jump got %b exp 11010010", outv());
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b1)
            $display("FAIL b2b_done got %b exp 1", done);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jumps();
        test_exc_ovf_div0();
        test_exc_jr();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
